// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control/serial/parallel inputs and register view outputs.
// The master modport drives the controls; the slave modport is the shift register itself.
interface universal_shift_reg_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout_r;
    logic             sout_l;
    logic [CntW-1:0]  shift_cnt;
    logic             done;

    modport master (
        output en, mode, sin_r, sin_l, pin,
        input  pout, sout_r, sout_l, shift_cnt, done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pin,
        output pout, sout_r, sout_l, shift_cnt, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load with a shared shift
// counter that pulses done every WIDTH shifts. Define ROTATE_EN to make shifts rotate.
module universal_shift_reg #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                  clk,
    input logic                  rst,
    universal_shift_reg_if.slave bus_io
);
    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ModeHold = 2'b00,
        ModeShr  = 2'b01,
        ModeShl  = 2'b10,
        ModeLoad = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift;
    logic             fill_r, fill_l;

    assign mode = mode_e'(bus_io.mode);

`ifdef ROTATE_EN
    assign fill_r = q_q[0];
    assign fill_l = q_q[WIDTH-1];
`else
    assign fill_r = bus_io.sin_r;
    assign fill_l = bus_io.sin_l;
`endif

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;
        if (bus_io.en) begin
            unique case (mode)
                ModeHold: begin
                end
                ModeShr: begin
                    q_d   = {fill_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                ModeShl: begin
                    q_d   = {q_q[WIDTH-2:0], fill_l};
                    shift = 1'b1;
                end
                ModeLoad: begin
                    q_d   = bus_io.pin;
                    cnt_d = '0;
                end
                default: begin
                end
            endcase
        end
        // Both directions advance the same counter; the word boundary ignores direction.
        if (shift) begin
            if (cnt_q == CntLast) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus_io.pout      = q_q;
    assign bus_io.sout_r    = q_q[0];
    assign bus_io.sout_l    = q_q[WIDTH-1];
    assign bus_io.shift_cnt = cnt_q;
    assign bus_io.done      = done_q;
endmodule
